// File: rtl/y_phase_scheduler.sv
// Vertical bicubic phase scheduler: walks an OUT_W x OUT_H output frame, requests
// 4-row tap windows, selects the weight-table phase and aligns out_valid with weight_sum.
module y_phase_scheduler #(
    parameter int OUT_W      = 8,
    parameter int OUT_H      = 8,
    parameter int PHASE_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  row_ack,
    output logic                  busy,
    output logic                  row_req,
    output logic [31:0]           tap_rows,
    output logic [PHASE_BITS-1:0] phase_sel,
    output logic                  col_valid,
    output logic [7:0]            col_idx,
    output logic                  out_valid,
    output logic [7:0]            out_row,
    output logic [7:0]            out_col,
    output logic                  last,
    output logic                  done
);

    localparam logic [7:0] LAST_COL = 8'(OUT_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(OUT_H - 1);
    localparam int         SRC_H    = OUT_H >> PHASE_BITS;
    localparam logic [8:0] SRC_MAX  = 9'(SRC_H - 1);

    typedef enum logic [2:0] {IDLE, FETCH, RUN, DRAIN, DONE} state_t;

    // Window {src+2, src+1, src, src-1}, each clamped to the source frame.
    function automatic logic [31:0] taps_for(input logic [7:0] src);
        logic [8:0] s;
        logic [8:0] t2;
        logic [8:0] t3;
        logic [7:0] t0;
        s  = {1'b0, src};
        t0 = (src == 8'd0) ? 8'd0 : src - 8'd1;
        t2 = (s + 9'd1 > SRC_MAX) ? SRC_MAX : s + 9'd1;
        t3 = (s + 9'd2 > SRC_MAX) ? SRC_MAX : s + 9'd2;
        return {8'(t3), 8'(t2), src, t0};
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            col_q, col_d;
    logic [7:0]            src_q, src_d;
    logic [PHASE_BITS-1:0] phase_q, phase_d;
    logic [PHASE_BITS-1:0] phase_next;
    logic [31:0]           tap_rows_q, tap_rows_d;
    logic                  row_req_q, row_req_d;
    logic                  out_valid_q, out_valid_d;
    logic [7:0]            out_row_q, out_row_d;
    logic [7:0]            out_col_q, out_col_d;
    logic                  last_q, last_d;
    logic                  col_valid_c;
    logic                  is_final;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        src_d       = src_q;
        phase_d     = phase_q;
        tap_rows_d  = tap_rows_q;
        row_req_d   = 1'b0;
        col_valid_c = 1'b0;
        phase_next  = phase_q + 1'b1;
        is_final    = (row_q == LAST_ROW) && (col_q == LAST_COL);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    row_d      = 8'd0;
                    col_d      = 8'd0;
                    src_d      = 8'd0;
                    phase_d    = '0;
                    tap_rows_d = taps_for(8'd0);
                    row_req_d  = 1'b1;
                end
            end
            FETCH: begin
                // An ack coincident with the request pulse is too early to trust.
                if (row_ack && !row_req_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    col_valid_c = 1'b1;
                    if (col_q != LAST_COL) begin
                        col_d = col_q + 8'd1;
                    end else if (row_q == LAST_ROW) begin
                        state_d = DRAIN;
                    end else begin
                        row_d   = row_q + 8'd1;
                        col_d   = 8'd0;
                        phase_d = phase_next;
                        if (phase_next == '0) begin
                            src_d      = src_q + 8'd1;
                            tap_rows_d = taps_for(src_q + 8'd1);
                            row_req_d  = 1'b1;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        out_valid_d = col_valid_c;
        out_row_d   = row_q;
        out_col_d   = col_q;
        last_d      = col_valid_c && is_final;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            src_q       <= 8'd0;
            phase_q     <= '0;
            tap_rows_q  <= 32'd0;
            row_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= 8'd0;
            out_col_q   <= 8'd0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            src_q       <= src_d;
            phase_q     <= phase_d;
            tap_rows_q  <= tap_rows_d;
            row_req_q   <= row_req_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            last_q      <= last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign row_req   = row_req_q;
    assign tap_rows  = tap_rows_q;
    assign phase_sel = phase_q;
    assign col_valid = col_valid_c;
    assign col_idx   = col_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign last      = last_q;

endmodule

// File: tb/tb_y_phase_scheduler.sv
// Directed bench for y_phase_scheduler with OUT_W=4, OUT_H=8, PHASE_BITS=2:
// nominal frame timing, stall, late ack, ignored start/ack, and mid-frame reset.
module tb_y_phase_scheduler;

    logic        clk = 1'b0;
    logic        rst, start, stall, row_ack;
    logic        busy, row_req, col_valid, out_valid, last, done;
    logic [31:0] tap_rows;
    logic [1:0]  phase_sel;
    logic [7:0]  col_idx, out_row, out_col;

    y_phase_scheduler #(.OUT_W(4), .OUT_H(8), .PHASE_BITS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .row_ack(row_ack),
        .busy(busy), .row_req(row_req), .tap_rows(tap_rows), .phase_sel(phase_sel),
        .col_valid(col_valid), .col_idx(col_idx), .out_valid(out_valid),
        .out_row(out_row), .out_col(out_col), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int t0 = 0;
    int rel;
    bit mon_on = 1'b0;
    bit auto_ack = 1'b1;
    int ack_delay = 1;
    int req_count, req1, req2, ov_count, ov_first, ov_last, done_rel, col_first;
    int order_err, col_err, last_count, exp_row, exp_col, col_row, col_col;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        req_count = 0; req1 = -1; req2 = -1; ov_count = 0; ov_first = -1; ov_last = -1;
        done_rel = -1; col_first = -1; order_err = 0; col_err = 0; last_count = 0;
        exp_row = 0; exp_col = 0; col_row = 0; col_col = 0;
        mon_on = 1'b1;
        t0 = cyc;
        start = 1'b1;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < t0 + n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int budget);
        int left;
        left = budget;
        while (done_rel < 0 && left > 0) begin
            @(posedge clk); #1;
            left--;
        end
        check_output("done_timeout", 32'(done_rel >= 0), 32'd1);
        @(negedge clk);
        check_output("busy_after_done", 32'(busy), 32'd0);
    endtask

    // Tracks the column and output streams against the expected raster order.
    always @(negedge clk) begin
        if (!rst && mon_on) begin
            rel = cyc - t0;
            if (row_req) begin
                req_count++;
                if (req_count == 1) req1 = rel;
                else if (req_count == 2) req2 = rel;
            end
            if (col_valid) begin
                if (col_first < 0) col_first = rel;
                if (col_idx !== 8'(col_col) || phase_sel !== 2'(col_row % 4) ||
                    tap_rows !== ((col_row < 4) ? 32'h01010000 : 32'h01010100))
                    col_err++;
                if (col_col == 3) begin col_col = 0; col_row++; end
                else col_col++;
            end
            if (out_valid) begin
                if (ov_first < 0) ov_first = rel;
                ov_last = rel;
                if (out_row !== 8'(exp_row) || out_col !== 8'(exp_col)) order_err++;
                if (last !== (ov_count == 31)) order_err++;
                if (last) last_count++;
                ov_count++;
                if (exp_col == 3) begin exp_col = 0; exp_row++; end
                else exp_col++;
            end
            if (done) done_rel = rel;
        end
    end

    // Acknowledges each row request ack_delay cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_ack && row_req && !rst) begin
                repeat (ack_delay) @(posedge clk);
                #1 row_ack = 1'b1;
                @(posedge clk);
                #1 row_ack = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; row_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_row_req", 32'(row_req), 32'd0);
        check_output("rst_tap_rows", tap_rows, 32'd0);
        check_output("rst_phase_sel", 32'(phase_sel), 32'd0);
        check_output("rst_col_valid", 32'(col_valid), 32'd0);
        check_output("rst_col_idx", 32'(col_idx), 32'd0);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        stall = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check_output("idle_stall_busy", 32'(busy), 32'd0);
        stall = 1'b0;

        $display("[TB] nominal frame");
        begin_frame();
        @(negedge clk);
        check_output("f1_busy_c0", 32'(busy), 32'd0);
        goto_cycle(1); start = 1'b0;
        @(negedge clk);
        check_output("f1_busy_c1", 32'(busy), 32'd1);
        check_output("f1_row_req_c1", 32'(row_req), 32'd1);
        check_output("f1_taps_src0", tap_rows, 32'h01010000);
        goto_cycle(3);
        @(negedge clk);
        check_output("f1_col_valid_c3", 32'(col_valid), 32'd1);
        goto_cycle(19);
        @(negedge clk);
        check_output("f1_taps_src1", tap_rows, 32'h01010100);
        wait_done(100);
        check_output("f1_req_count", 32'(req_count), 32'd2);
        check_output("f1_req1", 32'(req1), 32'd1);
        check_output("f1_req2", 32'(req2), 32'd19);
        check_output("f1_ov_count", 32'(ov_count), 32'd32);
        check_output("f1_ov_first", 32'(ov_first), 32'd4);
        check_output("f1_ov_last", 32'(ov_last), 32'd37);
        check_output("f1_done_rel", 32'(done_rel), 32'd38);
        check_output("f1_last_count", 32'(last_count), 32'd1);
        check_output("f1_order", 32'(order_err), 32'd0);
        check_output("f1_col_stream", 32'(col_err), 32'd0);

        $display("[TB] stall mid row 2");
        begin_frame();
        goto_cycle(1); start = 1'b0;
        goto_cycle(12); stall = 1'b1;
        @(negedge clk);
        check_output("st_col_valid_c12", 32'(col_valid), 32'd0);
        check_output("st_col_idx_c12", 32'(col_idx), 32'd1);
        goto_cycle(14);
        @(negedge clk);
        check_output("st_col_idx_c14", 32'(col_idx), 32'd1);
        goto_cycle(15); stall = 1'b0;
        @(negedge clk);
        check_output("st_col_valid_c15", 32'(col_valid), 32'd1);
        check_output("st_col_idx_c15", 32'(col_idx), 32'd1);
        wait_done(100);
        check_output("st_ov_count", 32'(ov_count), 32'd32);
        check_output("st_order", 32'(order_err), 32'd0);
        check_output("st_col_stream", 32'(col_err), 32'd0);
        check_output("st_done_rel", 32'(done_rel), 32'd41);

        $display("[TB] late row_ack");
        ack_delay = 10;
        begin_frame();
        goto_cycle(1); start = 1'b0;
        goto_cycle(11);
        @(negedge clk);
        check_output("ak_col_valid_c11", 32'(col_valid), 32'd0);
        check_output("ak_row_req_c11", 32'(row_req), 32'd0);
        check_output("ak_req_count_c11", 32'(req_count), 32'd1);
        goto_cycle(12);
        @(negedge clk);
        check_output("ak_col_valid_c12", 32'(col_valid), 32'd1);
        wait_done(150);
        check_output("ak_col_first", 32'(col_first), 32'd12);
        check_output("ak_req2", 32'(req2), 32'd28);
        check_output("ak_done_rel", 32'(done_rel), 32'd56);
        check_output("ak_ov_count", 32'(ov_count), 32'd32);
        check_output("ak_order", 32'(order_err), 32'd0);
        ack_delay = 1;

        $display("[TB] stray start and row_ack");
        begin_frame();
        goto_cycle(1); start = 1'b0;
        goto_cycle(5); start = 1'b1;
        goto_cycle(6); start = 1'b0;
        goto_cycle(8); row_ack = 1'b1;
        goto_cycle(9); row_ack = 1'b0;
        goto_cycle(20); start = 1'b1;
        goto_cycle(21); start = 1'b0;
        goto_cycle(30); row_ack = 1'b1;
        goto_cycle(31); row_ack = 1'b0;
        goto_cycle(38); start = 1'b1;
        @(negedge clk);
        check_output("sb_done_c38", 32'(done), 32'd1);
        goto_cycle(39); start = 1'b0;
        @(negedge clk);
        check_output("sb_busy_c39", 32'(busy), 32'd0);
        goto_cycle(40);
        @(negedge clk);
        check_output("sb_row_req_c40", 32'(row_req), 32'd0);
        check_output("sb_ov_count", 32'(ov_count), 32'd32);
        check_output("sb_req_count", 32'(req_count), 32'd2);
        check_output("sb_done_rel", 32'(done_rel), 32'd38);
        check_output("sb_order", 32'(order_err), 32'd0);

        $display("[TB] reset mid frame");
        begin_frame();
        goto_cycle(1); start = 1'b0;
        goto_cycle(27);
        @(negedge clk);
        check_output("mr_col_idx_r5", 32'(col_idx), 32'd2);
        check_output("mr_phase_r5", 32'(phase_sel), 32'd1);
        check_output("mr_col_valid_r5", 32'(col_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_output("mr_busy", 32'(busy), 32'd0);
        check_output("mr_col_valid", 32'(col_valid), 32'd0);
        check_output("mr_col_idx", 32'(col_idx), 32'd0);
        check_output("mr_out_valid", 32'(out_valid), 32'd0);
        check_output("mr_tap_rows", tap_rows, 32'd0);
        check_output("mr_phase_sel", 32'(phase_sel), 32'd0);
        check_output("mr_out_row", 32'(out_row), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        begin_frame();
        goto_cycle(1); start = 1'b0;
        @(negedge clk);
        check_output("mr2_row_req", 32'(row_req), 32'd1);
        check_output("mr2_taps", tap_rows, 32'h01010000);
        check_output("mr2_phase", 32'(phase_sel), 32'd0);
        goto_cycle(3);
        @(negedge clk);
        check_output("mr2_col_valid", 32'(col_valid), 32'd1);
        check_output("mr2_col_idx", 32'(col_idx), 32'd0);
        wait_done(100);
        check_output("mr2_ov_count", 32'(ov_count), 32'd32);
        check_output("mr2_order", 32'(order_err), 32'd0);
        check_output("mr2_col_stream", 32'(col_err), 32'd0);
        check_output("mr2_done_rel", 32'(done_rel), 32'd38);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
